vp_crop: RTL and testbench

VP_CROP -- requirements
Module: vp_crop

---
 rtl/vp_pkg.sv | 21 ++
 rtl/vp_xy_cnt.sv | 57 +++++
 rtl/vp_crop.sv | 161 ++++++++++++++++
 tb/tb_vp_crop.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared constants for the video crop/mask path: mode encodings and the
// configuration loaded on reset.
package vp_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_CROP   = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int unsigned MAX_COORD_W = 16;
    localparam int unsigned MAX_DATA_W  = 32;

    // Reset configuration: bypass, full-frame window, black fill.
    localparam logic [1:0]             RST_MODE  = MODE_BYPASS;
    localparam logic [MAX_COORD_W-1:0] RST_START = '0;
    localparam logic [MAX_COORD_W-1:0] RST_END   = '1;
    localparam logic [MAX_DATA_W-1:0]  RST_FILL  = '0;

endpackage

// File: rtl/vp_xy_cnt.sv
// Column/row position tracker and window membership test for the pixel
// currently presented on the input.
module vp_xy_cnt #(
    parameter int unsigned X_W = 11,
    parameter int unsigned Y_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vs_rise_i,
    input  logic           de_i,
    input  logic [X_W-1:0] start_x_i,
    input  logic [X_W-1:0] end_x_i,
    input  logic [Y_W-1:0] start_y_i,
    input  logic [Y_W-1:0] end_y_i,
    output logic           in_win_c_o
);

    logic           de_q;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           de_fall;

    assign de_fall = de_q & ~de_i;

    // x holds the index of the current pixel; both counters saturate.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vs_rise_i || de_fall) begin
            x_d = '0;
        end else if (de_i && (x_q != '1)) begin
            x_d = x_q + X_W'(1);
        end
        if (vs_rise_i) begin
            y_d = '0;
        end else if (de_fall && (y_q != '1)) begin
            y_d = y_q + Y_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            de_q <= de_i;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    // Ends are exclusive, so start >= end naturally yields an empty window.
    assign in_win_c_o = (x_q >= start_x_i) && (x_q < end_x_i) &&
                        (y_q >= start_y_i) && (y_q < end_y_i);

endmodule

// File: rtl/vp_crop.sv
// Video crop / mask-fill stage with frame-synchronous configuration update
// and per-frame pixel statistics.
module vp_crop
    import vp_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned X_W    = 11,
    parameter int unsigned Y_W    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pre_vs,
    input  logic               pre_de,
    input  logic [DATA_W-1:0]  pre_data,
    input  logic [1:0]         cfg_mode,
    input  logic [X_W-1:0]     cfg_start_x,
    input  logic [Y_W-1:0]     cfg_start_y,
    input  logic [X_W-1:0]     cfg_end_x,
    input  logic [Y_W-1:0]     cfg_end_y,
    input  logic [DATA_W-1:0]  cfg_fill,
    input  logic               cfg_valid,
    output logic               post_vs,
    output logic               post_de,
    output logic [DATA_W-1:0]  post_data,
    output logic               cfg_pending,
    output logic [X_W+Y_W-1:0] last_px,
    output logic [15:0]        frame_cnt
);

    localparam int unsigned PIX_W = X_W + Y_W;

    logic              vs_q, vs_rise, live_q, pend_q, in_win;
    logic [1:0]        stg_mode_q, act_mode_q;
    logic [X_W-1:0]    stg_sx_q, stg_ex_q, act_sx_q, act_ex_q;
    logic [Y_W-1:0]    stg_sy_q, stg_ey_q, act_sy_q, act_ey_q;
    logic [DATA_W-1:0] stg_fill_q, act_fill_q;
    logic              post_vs_q, post_de_q, post_de_d;
    logic [DATA_W-1:0] post_data_q, post_data_d;
    logic [PIX_W-1:0]  pix_q, pix_d, last_q;
    logic [15:0]       frame_q;

    assign vs_rise = pre_vs & ~vs_q;

    // Staged config is promoted only at frame start; a load in that same
    // cycle bypasses the staging registers so it governs the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q       <= 1'b0;
            live_q     <= 1'b0;
            pend_q     <= 1'b0;
            stg_mode_q <= RST_MODE;
            stg_sx_q   <= X_W'(RST_START);
            stg_sy_q   <= Y_W'(RST_START);
            stg_ex_q   <= X_W'(RST_END);
            stg_ey_q   <= Y_W'(RST_END);
            stg_fill_q <= DATA_W'(RST_FILL);
            act_mode_q <= RST_MODE;
            act_sx_q   <= X_W'(RST_START);
            act_sy_q   <= Y_W'(RST_START);
            act_ex_q   <= X_W'(RST_END);
            act_ey_q   <= Y_W'(RST_END);
            act_fill_q <= DATA_W'(RST_FILL);
        end else begin
            vs_q <= pre_vs;
            if (cfg_valid) begin
                stg_mode_q <= cfg_mode;
                stg_sx_q   <= cfg_start_x;
                stg_sy_q   <= cfg_start_y;
                stg_ex_q   <= cfg_end_x;
                stg_ey_q   <= cfg_end_y;
                stg_fill_q <= cfg_fill;
            end
            if (vs_rise) begin
                live_q     <= 1'b1;
                pend_q     <= 1'b0;
                act_mode_q <= cfg_valid ? cfg_mode    : stg_mode_q;
                act_sx_q   <= cfg_valid ? cfg_start_x : stg_sx_q;
                act_sy_q   <= cfg_valid ? cfg_start_y : stg_sy_q;
                act_ex_q   <= cfg_valid ? cfg_end_x   : stg_ex_q;
                act_ey_q   <= cfg_valid ? cfg_end_y   : stg_ey_q;
                act_fill_q <= cfg_valid ? cfg_fill    : stg_fill_q;
            end else if (cfg_valid) begin
                pend_q <= 1'b1;
            end
        end
    end

    vp_xy_cnt #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_xy_cnt (
        .clk        (clk),
        .rst        (rst),
        .vs_rise_i  (vs_rise),
        .de_i       (pre_de),
        .start_x_i  (act_sx_q),
        .end_x_i    (act_ex_q),
        .start_y_i  (act_sy_q),
        .end_y_i    (act_ey_q),
        .in_win_c_o (in_win)
    );

    // Output is suppressed until the first frame start after reset.
    always_comb begin
        post_de_d   = 1'b0;
        post_data_d = '0;
        if (live_q) begin
            case (act_mode_q)
                MODE_CROP: begin
                    post_de_d   = pre_de & in_win;
                    post_data_d = (pre_de && in_win) ? pre_data : '0;
                end
                MODE_FILL: begin
                    post_de_d   = pre_de;
                    post_data_d = pre_de ? (in_win ? pre_data : act_fill_q) : '0;
                end
                default: begin
                    post_de_d   = pre_de;
                    post_data_d = pre_data;
                end
            endcase
        end
    end

    always_comb begin
        pix_d = pix_q;
        if (vs_rise) begin
            pix_d = '0;
        end else if (post_de_q && (pix_q != '1)) begin
            pix_d = pix_q + PIX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_vs_q   <= 1'b0;
            post_de_q   <= 1'b0;
            post_data_q <= '0;
            pix_q       <= '0;
            last_q      <= '0;
            frame_q     <= '0;
        end else begin
            post_vs_q   <= pre_vs;
            post_de_q   <= post_de_d;
            post_data_q <= post_data_d;
            pix_q       <= pix_d;
            if (vs_rise) begin
                last_q  <= pix_q;
                frame_q <= frame_q + 16'(1);
            end
        end
    end

    assign post_vs     = post_vs_q;
    assign post_de     = post_de_q;
    assign post_data   = post_data_q;
    assign cfg_pending = pend_q;
    assign last_px     = last_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vp_crop.sv
// Directed bench for vp_crop: bypass, crop, mask-fill, mid-frame config,
// empty window and mid-frame reset scenarios on small frames.
module tb_vp_crop;

    logic        clk = 1'b0;
    logic        rst;
    logic        pre_vs, pre_de;
    logic [23:0] pre_data;
    logic [1:0]  cfg_mode;
    logic [10:0] cfg_start_x, cfg_end_x;
    logic [10:0] cfg_start_y, cfg_end_y;
    logic [23:0] cfg_fill;
    logic        cfg_valid;
    logic        post_vs, post_de;
    logic [23:0] post_data;
    logic        cfg_pending;
    logic [21:0] last_px;
    logic [15:0] frame_cnt;

    int total  = 0;
    int passed = 0;
    int exp_frames = 0;

    vp_crop dut (
        .clk         (clk),
        .rst         (rst),
        .pre_vs      (pre_vs),
        .pre_de      (pre_de),
        .pre_data    (pre_data),
        .cfg_mode    (cfg_mode),
        .cfg_start_x (cfg_start_x),
        .cfg_start_y (cfg_start_y),
        .cfg_end_x   (cfg_end_x),
        .cfg_end_y   (cfg_end_y),
        .cfg_fill    (cfg_fill),
        .cfg_valid   (cfg_valid),
        .post_vs     (post_vs),
        .post_de     (post_de),
        .post_data   (post_data),
        .cfg_pending (cfg_pending),
        .last_px     (last_px),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] m, input int sx, input int sy,
                           input int ex, input int ey, input logic [23:0] f);
        cfg_mode    = m;
        cfg_start_x = 11'(sx);
        cfg_start_y = 11'(sy);
        cfg_end_x   = 11'(ex);
        cfg_end_y   = 11'(ey);
        cfg_fill    = f;
    endtask

    task automatic load_cfg;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total++;
        if (cfg_pending !== 1'b1) $display("FAIL load_pending got=%b exp=1", cfg_pending);
        else passed++;
    endtask

    task automatic vs_pulse(input int exp_last, input bit cfg_with_vs);
        pre_de    = 1'b0;
        pre_data  = '0;
        pre_vs    = 1'b1;
        cfg_valid = cfg_with_vs;
        tick();
        cfg_valid = 1'b0;
        exp_frames = (exp_frames + 1) % 65536;
        total++;
        if (post_vs !== 1'b1) $display("FAIL vs_hi got=%b exp=1", post_vs);
        else passed++;
        total++;
        if (frame_cnt !== 16'(exp_frames)) $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
        else passed++;
        total++;
        if (last_px !== 22'(exp_last)) $display("FAIL last_px got=%0d exp=%0d", last_px, exp_last);
        else passed++;
        total++;
        if (cfg_pending !== 1'b0) $display("FAIL pending_clr got=%b exp=0", cfg_pending);
        else passed++;
        pre_vs = 1'b0;
        tick();
        total++;
        if (post_vs !== 1'b0) $display("FAIL vs_lo got=%b exp=0", post_vs);
        else passed++;
        tick();
    endtask

    task automatic run_frame(input int w, input int h, input logic [1:0] mode,
                             input int sx, input int sy, input int ex, input int ey,
                             input logic [23:0] fill, input int exp_last,
                             input bit cfg_with_vs, input bit cfg_mid,
                             output int n_de, output logic [23:0] first);
        bit          in_w, e_de, got;
        logic [23:0] d, e_data;
        vs_pulse(exp_last, cfg_with_vs);
        n_de  = 0;
        first = '0;
        got   = 1'b0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                d        = 24'(x + 16 * y);
                pre_de   = 1'b1;
                pre_data = d;
                if (cfg_mid && y == 1 && x == 3) cfg_valid = 1'b1;
                tick();
                cfg_valid = 1'b0;
                in_w = (x >= sx) && (x < ex) && (y >= sy) && (y < ey);
                case (mode)
                    2'b01:   begin e_de = in_w; e_data = in_w ? d : 24'h0; end
                    2'b10:   begin e_de = 1'b1; e_data = in_w ? d : fill;  end
                    default: begin e_de = 1'b1; e_data = d;                end
                endcase
                total++;
                if (post_de !== e_de) $display("FAIL px_de x=%0d y=%0d got=%b exp=%b", x, y, post_de, e_de);
                else passed++;
                total++;
                if (post_data !== e_data) $display("FAIL px_data x=%0d y=%0d got=%h exp=%h", x, y, post_data, e_data);
                else passed++;
                if (cfg_mid && y == 1 && x == 3) begin
                    total++;
                    if (cfg_pending !== 1'b1) $display("FAIL mid_pending got=%b exp=1", cfg_pending);
                    else passed++;
                end
                if (post_de === 1'b1) begin
                    n_de++;
                    if (!got) begin first = post_data; got = 1'b1; end
                end
            end
            for (int g = 0; g < 2; g++) begin
                pre_de   = 1'b0;
                pre_data = 24'hABCDEF;
                tick();
                total++;
                if (post_de !== 1'b0) $display("FAIL gap_de y=%0d got=%b exp=0", y, post_de);
                else passed++;
                if (mode != 2'b10) begin
                    e_data = (mode == 2'b01) ? 24'h0 : 24'hABCDEF;
                    total++;
                    if (post_data !== e_data) $display("FAIL gap_data y=%0d got=%h exp=%h", y, post_data, e_data);
                    else passed++;
                end
            end
        end
        pre_data = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        pre_vs = 1'b1;
        tick();
        total++;
        if ({post_vs, post_de, post_data} !== 26'h0) $display("FAIL rst_post got=%b%b%h exp=0", post_vs, post_de, post_data);
        else passed++;
        total++;
        if ({cfg_pending, last_px, frame_cnt} !== 39'h0) $display("FAIL rst_stats got=%b/%0d/%0d exp=0", cfg_pending, last_px, frame_cnt);
        else passed++;
        rst = 1'b0;
        tick();
        exp_frames = 1;
        total++;
        if (frame_cnt !== 16'd1) $display("FAIL first_vs_rise got=%0d exp=1", frame_cnt);
        else passed++;
        pre_vs = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_bypass;
        int n; logic [23:0] f;
        run_frame(8, 4, 2'b00, 0, 0, 2047, 2047, 24'h0, 0, 1'b0, 1'b0, n, f);
        total++;
        if (n != 32) $display("FAIL bypass_count got=%0d exp=32", n);
        else passed++;
    endtask

    task automatic test_crop;
        int n; logic [23:0] f;
        set_cfg(2'b01, 2, 1, 6, 3, 24'h0);
        load_cfg();
        run_frame(8, 4, 2'b01, 2, 1, 6, 3, 24'h0, 32, 1'b0, 1'b0, n, f);
        total++;
        if (n != 8) $display("FAIL crop_count got=%0d exp=8", n);
        else passed++;
        total++;
        if (f !== 24'h000012) $display("FAIL crop_first got=%h exp=000012", f);
        else passed++;
    endtask

    task automatic test_fill;
        int n; logic [23:0] f;
        set_cfg(2'b10, 2, 1, 6, 3, 24'hFF0000);
        load_cfg();
        run_frame(8, 4, 2'b10, 2, 1, 6, 3, 24'hFF0000, 8, 1'b0, 1'b0, n, f);
        total++;
        if (n != 32) $display("FAIL fill_count got=%0d exp=32", n);
        else passed++;
    endtask

    task automatic test_mid_cfg;
        int n; logic [23:0] f;
        set_cfg(2'b01, 2, 1, 6, 3, 24'h0);
        load_cfg();
        set_cfg(2'b10, 2, 1, 6, 3, 24'hFF0000);
        run_frame(8, 4, 2'b01, 2, 1, 6, 3, 24'h0, 32, 1'b0, 1'b1, n, f);
        total++;
        if (n != 8) $display("FAIL mid_crop_count got=%0d exp=8", n);
        else passed++;
        total++;
        if (cfg_pending !== 1'b1) $display("FAIL mid_pending_end got=%b exp=1", cfg_pending);
        else passed++;
        run_frame(8, 4, 2'b10, 2, 1, 6, 3, 24'hFF0000, 8, 1'b0, 1'b0, n, f);
        total++;
        if (n != 32) $display("FAIL mid_fill_count got=%0d exp=32", n);
        else passed++;
    endtask

    task automatic test_empty;
        int n; logic [23:0] f;
        set_cfg(2'b01, 5, 0, 5, 4, 24'h0);
        run_frame(8, 4, 2'b01, 5, 0, 5, 4, 24'h0, 32, 1'b1, 1'b0, n, f);
        total++;
        if (n != 0) $display("FAIL empty_count got=%0d exp=0", n);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int n; logic [23:0] f;
        vs_pulse(0, 1'b0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 16; x++) begin
                pre_de   = 1'b1;
                pre_data = 24'(x + 16 * y);
                if (y == 2 && x == 10) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    exp_frames = 0;
                    total++;
                    if ({post_vs, post_de, post_data} !== 26'h0) $display("FAIL midrst_post got=%b%b%h exp=0", post_vs, post_de, post_data);
                    else passed++;
                    total++;
                    if ({cfg_pending, last_px, frame_cnt} !== 39'h0) $display("FAIL midrst_stats got=%b/%0d/%0d exp=0", cfg_pending, last_px, frame_cnt);
                    else passed++;
                end else begin
                    tick();
                    if (y > 2 || (y == 2 && x > 10)) begin
                        total++;
                        if (post_de !== 1'b0) $display("FAIL postrst_de x=%0d y=%0d got=%b exp=0", x, y, post_de);
                        else passed++;
                    end
                end
            end
            pre_de = 1'b0;
            tick();
            tick();
        end
        set_cfg(2'b01, 2, 1, 6, 3, 24'h0);
        load_cfg();
        run_frame(8, 4, 2'b01, 2, 1, 6, 3, 24'h0, 0, 1'b0, 1'b0, n, f);
        total++;
        if (n != 8) $display("FAIL postrst_crop got=%0d exp=8", n);
        else passed++;
        total++;
        if (f !== 24'h000012) $display("FAIL postrst_first got=%h exp=000012", f);
        else passed++;
        vs_pulse(8, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        pre_vs    = 1'b0;
        pre_de    = 1'b0;
        pre_data  = '0;
        cfg_valid = 1'b0;
        set_cfg(2'b00, 0, 0, 2047, 2047, 24'h0);
        test_reset();
        test_bypass();
        test_crop();
        test_fill();
        test_mid_cfg();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
